bsg_chip_noc_mc_credit_limiter: RTL
===================================

// Module: bsg_chip_noc_mc_credit_limiter
// PURPOSE
//  Sits between the manycore SDR link core side and the manycore endpoint on the NoC clock.
//  Caps outstanding forward (request) packets using a credit counter: each fwd packet sent
//  consumes one credit, and each rev (return) packet delivered refunds one.
//  Also provides a drain/quiesce FSM so software can idle the link before an SDR link reset.
// PARAMETERS
//  fwd_width_p    118  manycore fwd packet width (bsg_manycore_packet_width)
//  rev_width_p    71   manycore rev packet width (bsg_manycore_return_packet_width)
//  max_credits_p  32   hard ceiling on outstanding fwd packets; must be >=1
//  (derived) cw_lp = $clog2(max_credits_p+1)  credit counter width
// PORTS
//  clk_i            in   1            NoC clock
//  reset_n_i        in   1            synchronous reset, active-low
//  fwd_v_i          in   1            fwd packet valid from SDR link core side
//  fwd_data_i       in   fwd_width_p  fwd packet
//  fwd_ready_and_o  out  1            ready-and toward SDR link
//  fwd_v_o          out  1            fwd packet valid to endpoint
//  fwd_data_o       out  fwd_width_p  fwd packet
//  fwd_ready_and_i  in   1            endpoint ready-and
//  rev_v_i          in   1            rev packet valid from endpoint
//  rev_data_i       in   rev_width_p  rev packet
//  rev_ready_and_o  out  1            ready-and toward endpoint
//  rev_v_o          out  1            rev packet valid to SDR link
//  rev_data_o       out  rev_width_p  rev packet
//  rev_ready_and_i  in   1            SDR link ready-and
//  credit_limit_i   in   cw_lp        runtime cap; effective = min(credit_limit_i, max_credits_p)
//  drain_i          in   1            request quiesce (level)
//  credits_used_o   out  cw_lp        current outstanding count
//  idle_o           out  1            1 in eIdle
//  underflow_o      out  1            sticky: rev returned with zero credits outstanding
// BEHAVIOUR
//  - Reset (reset_n_i==0 at posedge): counter=0, FIFO empty, state=eRun, underflow_o=0.
//    During/after reset: fwd_v_o=0, idle_o=0, credits_used_o=0.
//  - Fwd path: a 2-entry FIFO (bsg_two_fifo); fwd_ready_and_o = FIFO ready. Minimum latency is
//    1 cycle (input handshake at cycle N -> fwd_v_o at N+1). Full throughput when credits allow.
//  - Issue: fwd_v_o = fifo_v & (state==eRun) & (used < eff_limit).
//    A send occurs on fwd_v_o & fwd_ready_and_i. fwd_v_o never depends on fwd_ready_and_i.
//  - Rev path: combinational pass-through, with rev_v_o=rev_v_i and rev_ready_and_o=rev_ready_and_i.
//    A return occurs on rev_v_i & rev_ready_and_i.
//  - Counter: send only -> +1; return only -> -1; both in the same cycle -> unchanged.
//    The counter never exceeds max_credits_p, which the issue gate guarantees.
//    A return with used==0 (and no send) holds 0 and sets underflow_o. underflow_o clears only on reset.
//    With used==0, a return plus a send in the same cycle -> net 0, and underflow is NOT flagged.
//  - Limit: eff_limit==0 blocks all issue.
//    Lowering the limit below used does not drop anything; issue resumes once used < eff_limit.
//  - FSM:
//    eRun   -> eDrain when drain_i=1.
//    eDrain -> eIdle when used==0 & fwd FIFO empty (FIFO contents stay buffered, gated, in eDrain;
//              they are not issued). Note: a non-empty FIFO keeps eDrain until drain_i drops.
//    eDrain -> eRun when drain_i=0.
//    eIdle  -> eRun when drain_i=0.
//    In eDrain/eIdle: fwd_v_o=0 and fwd_ready_and_o=0 (no new intake). Rev path stays live.
//  - A reset mid-operation discards FIFO contents and outstanding credit state; the endpoint must
//    be reset in the same window.
// STRUCTURE
//  - Shared package bsg_chip_pkg: mc_credit_max_gp (=32) and the enum
//    bsg_mc_credit_state_e {eRun, eDrain, eIdle}.
//  - Sub-module bsg_mc_credit_counter: up/down/saturate counter with an underflow flag.
//  - Top level: FSM, issue gate, bsg_two_fifo.
// TESTING
//  1. limit=4, endpoint always ready, no rev, 10 fwd pkts -> exactly 4 issued; used=4; fwd_v_o=0.
//     Then 1 rev -> 5th pkt issued the next cycle.
//  2. used=3, send and return in the same cycle -> used stays 3. Repeat for 20 cycles -> used=3.
//  3. Back-to-back fwd with limit=32, fast rev returns -> 1 pkt/cycle after 1-cycle latency,
//     data order preserved.
//  4. limit=8, used=6, set limit=2 -> no issue until 5 rev returns make used=1; then issue resumes.
//  5. drain_i=1 with used=2 and FIFO empty -> eDrain, fwd_ready_and_o=0; after 2 revs -> idle_o=1.
//     drain_i=0 -> eRun the next cycle.
//  6. used=0, single rev -> underflow_o=1 and used=0. Assert reset_n_i low mid-traffic
//     (used=5, FIFO full) -> used=0, fwd_v_o=0, underflow_o=0.

Source files
------------

// File: rtl/bsg_chip_pkg.sv
// Shared manycore chip definitions: credit ceiling and the credit limiter's
// quiesce state encoding.
package bsg_chip_pkg;

  localparam int mc_credit_max_gp = 32;

  typedef enum logic [1:0] {
    eRun   = 2'd0,
    eDrain = 2'd1,
    eIdle  = 2'd2
  } bsg_mc_credit_state_e;

endpackage

// File: rtl/bsg_mc_credit_counter.sv
// Outstanding-credit counter: +1 per send, -1 per return, saturating at both
// ends, with a sticky flag for a return that arrives with nothing outstanding.
module bsg_mc_credit_counter
  import bsg_chip_pkg::*;
#(
  parameter  int max_p = mc_credit_max_gp,
  localparam int cw_lp = $clog2(max_p + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [cw_lp-1:0] count_o,
  output logic             underflow_o
);

  logic [cw_lp-1:0] r_count;
  logic             r_underflow;

  assign count_o     = r_count;
  assign underflow_o = r_underflow;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (up_i && !down_i) begin
      if (r_count != cw_lp'(max_p)) r_count <= r_count + cw_lp'(1);
    end else if (down_i && !up_i) begin
      if (r_count == '0) r_underflow <= 1'b1;
      else               r_count     <= r_count - cw_lp'(1);
    end
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO; full throughput with one cycle of latency.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_cnt;
  logic               w_enq;
  logic               w_deq;

  assign ready_and_o = (r_cnt != 2'd2);
  assign v_o         = (r_cnt != 2'd0);
  assign data_o      = r_mem[r_rptr];
  assign w_enq       = v_i & ready_and_o;
  assign w_deq       = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + 2'(w_enq) - 2'(w_deq);
    end
  end

  // NOTE: storage is left unreset; occupancy alone decides whether a slot is meaningful.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bsg_chip_noc_mc_credit_limiter.sv
// Caps outstanding manycore fwd packets with a credit counter refunded by rev
// packets, and offers a drain/idle handshake so the SDR link can be quiesced.
module bsg_chip_noc_mc_credit_limiter
  import bsg_chip_pkg::*;
#(
  parameter  int fwd_width_p   = 118,
  parameter  int rev_width_p   = 71,
  parameter  int max_credits_p = mc_credit_max_gp,
  localparam int cw_lp         = $clog2(max_credits_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   fwd_v_i,
  input  logic [fwd_width_p-1:0] fwd_data_i,
  output logic                   fwd_ready_and_o,
  output logic                   fwd_v_o,
  output logic [fwd_width_p-1:0] fwd_data_o,
  input  logic                   fwd_ready_and_i,
  input  logic                   rev_v_i,
  input  logic [rev_width_p-1:0] rev_data_i,
  output logic                   rev_ready_and_o,
  output logic                   rev_v_o,
  output logic [rev_width_p-1:0] rev_data_o,
  input  logic                   rev_ready_and_i,
  input  logic [cw_lp-1:0]       credit_limit_i,
  input  logic                   drain_i,
  output logic [cw_lp-1:0]       credits_used_o,
  output logic                   idle_o,
  output logic                   underflow_o
);

  bsg_mc_credit_state_e   r_state;
  logic                   r_idle;
  logic                   w_run;
  logic                   w_fifo_v;
  logic                   w_fifo_ready;
  logic [fwd_width_p-1:0] w_fifo_data;
  logic                   w_fwd_v;
  logic                   w_send;
  logic                   w_ret;
  logic [cw_lp-1:0]       w_used;
  logic [cw_lp-1:0]       w_eff_limit;

  assign w_run       = (r_state == eRun);
  assign w_eff_limit = (credit_limit_i > cw_lp'(max_credits_p)) ? cw_lp'(max_credits_p)
                                                                 : credit_limit_i;

  // Issue is gated by state and credit only, so fwd_v_o never waits on the endpoint's ready.
  assign w_fwd_v = w_fifo_v & w_run & (w_used < w_eff_limit);
  assign w_send  = w_fwd_v & fwd_ready_and_i;
  assign w_ret   = rev_v_i & rev_ready_and_i;

  assign fwd_v_o         = w_fwd_v;
  assign fwd_data_o      = w_fifo_data;
  assign fwd_ready_and_o = w_fifo_ready & w_run;

  assign rev_v_o         = rev_v_i;
  assign rev_data_o      = rev_data_i;
  assign rev_ready_and_o = rev_ready_and_i;

  assign credits_used_o = w_used;
  assign idle_o         = r_idle;

  bsg_two_fifo #(
    .width_p (fwd_width_p)
  ) u_fwd_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (fwd_v_i & w_run),
    .data_i      (fwd_data_i),
    .ready_and_o (w_fifo_ready),
    .v_o         (w_fifo_v),
    .data_o      (w_fifo_data),
    .yumi_i      (w_send)
  );

  bsg_mc_credit_counter #(
    .max_p (max_credits_p)
  ) u_credit_counter (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .up_i        (w_send),
    .down_i      (w_ret),
    .count_o     (w_used),
    .underflow_o (underflow_o)
  );

  // Buffered fwd packets stay parked while draining, so idle needs an empty FIFO too.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= eRun;
      r_idle  <= 1'b0;
    end else begin
      unique case (r_state)
        eRun: begin
          if (drain_i) r_state <= eDrain;
        end
        eDrain: begin
          if (!drain_i) begin
            r_state <= eRun;
          end else if (w_used == '0 && !w_fifo_v) begin
            r_state <= eIdle;
            r_idle  <= 1'b1;
          end
        end
        eIdle: begin
          if (!drain_i) begin
            r_state <= eRun;
            r_idle  <= 1'b0;
          end
        end
        default: begin
          r_state <= eRun;
          r_idle  <= 1'b0;
        end
      endcase
    end
  end

endmodule
